// File: rtl/uart_tx_serializer_if.sv
// Byte handshake into the UART transmit stage.
//
// Handshake: the producer drives tx_data and raises tx_valid; a byte moves
// on every rising clock edge where tx_valid && tx_ready are both high. While
// tx_valid is high and tx_ready is low, the producer keeps tx_data stable
// and keeps tx_valid high. tx_ready does not depend on tx_valid.
//
// Signals:
//   tx_data  - byte to transmit (DATA_BITS wide), producer -> stage
//   tx_valid - tx_data is valid this cycle, producer -> stage
//   tx_ready - stage can take a byte this cycle, stage -> producer
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: small byte FIFO feeding a frame serialiser.
// Frame: start bit (0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Each bit lasts one baud_tick interval.
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-high reset
//   baud_tick  - one-clock enable, once per bit period
//   tx_if      - byte handshake (slave side: tx_data, tx_valid, tx_ready)
//   txd        - registered serial line, idle/mark = 1
//   tx_busy    - frame in progress or FIFO non-empty
//   fifo_count - FIFO occupancy
//   state_dbg  - current serialiser state (debug)
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  baud_tick,
  uart_tx_serializer_if.slave   tx_if,
  output logic                  txd,
  output logic                  tx_busy,
  output logic [CW-1:0]         fifo_count,
  output logic [2:0]            state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic                 push;
  logic                 pop;
  logic                 fifo_nonempty;
  logic [DATA_BITS-1:0] head;

  // Serialiser state
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;

  assign tx_if.tx_ready = (count_q != FULL);
  assign push           = tx_if.tx_valid && tx_if.tx_ready;
  assign fifo_nonempty  = (count_q != '0);
  assign head           = mem[rd_ptr];

  assign txd        = txd_q;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != S_IDLE) || fifo_nonempty;
  assign state_dbg  = state_q;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= tx_if.tx_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // txd is reset to mark so an aborted frame drops straight back to idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
    end
  end

  // Every transition is gated by baud_tick. txd_d is the value the line
  // takes for the bit period that begins at this tick.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    txd_d      = txd_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (baud_tick && fifo_nonempty) begin
          pop     = 1'b1;
          shreg_d = head;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          txd_d     = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
          par_d     = shreg_q[0];
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY != 0) begin
              // par_q holds the XOR of all data bits sent.
              txd_d   = (PARITY == 1) ? ~par_q : par_q;
              state_d = S_PARITY;
            end else begin
              txd_d      = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            par_d     = par_q ^ shreg_q[0];
          end
        end
      end

      S_PARITY: begin
        if (baud_tick) begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            if (fifo_nonempty) begin
              // Back-to-back: next start bit follows the stop bit directly.
              pop     = 1'b1;
              shreg_d = head;
              txd_d   = 1'b0;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
